// File: rtl/mdio_phy_arbiter_if.sv
// Requester-side handshake bundle for the shared MDIO arbiter.
// Three requesters are packed side by side; [0]=U, [1]=A, [2]=B.
interface mdio_phy_arbiter_if;
    logic [2:0]  req;
    logic [2:0]  wr;
    logic [14:0] reg_addr;
    logic [47:0] wdata;
    logic [2:0]  done;
    logic [15:0] rdata;
    logic        rd_err;
    logic        busy;

    modport master (output req, wr, reg_addr, wdata, input done, rdata, rd_err, busy);
    modport slave  (input req, wr, reg_addr, wdata, output done, rdata, rd_err, busy);
endinterface

// File: rtl/mdio_phy_arbiter.sv
// Round-robin arbiter that shares one Clause-22 MDIO bus among three PHY ports,
// serialising a 64-bit frame per grant on a divided MDC and returning read data.
module mdio_phy_arbiter #(
    parameter int         CLK_FREQ   = 125_000_000,
    parameter int         MDC_FREQ   = 2_500_000,
    parameter logic [4:0] PHY_ADDR_U = 5'd1,
    parameter logic [4:0] PHY_ADDR_A = 5'd2,
    parameter logic [4:0] PHY_ADDR_B = 5'd3
) (
    input  logic               gtx_clk,
    input  logic               reset,
    mdio_phy_arbiter_if.slave  bus,
    output logic               mdc,
    output logic               mdio_o,
    output logic               mdio_oe,
    input  logic               mdio_i
);
    localparam int HALF  = CLK_FREQ / (2 * MDC_FREQ);
    localparam int DIV_W = $clog2(2 * HALF);
    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(HALF - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * HALF - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_FRAME = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         idx_q, idx_d;
    logic               wr_q, wr_d;
    logic [31:0]        word_q, word_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [5:0]         bit_q, bit_d;
    logic [15:0]        rsh_q, rsh_d;
    logic               ta_q, ta_d;
    logic [2:0]         done_q, done_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               rd_err_q, rd_err_d;
    logic               busy_q, busy_d;
    logic               mdc_q, mdc_d;
    logic               mdio_o_q, mdio_o_d;
    logic               mdio_oe_q, mdio_oe_d;
    logic [1:0]         pick_s;
    logic               pick_wr_s;
    logic [5:0]         bit_nx_s;

    // First asserted requester searching upward from the one after ptr.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [2:0] rq);
        logic [1:0] pick;
        case (ptr)
            2'd0:    pick = rq[1] ? 2'd1 : (rq[2] ? 2'd2 : 2'd0);
            2'd1:    pick = rq[2] ? 2'd2 : (rq[0] ? 2'd0 : 2'd1);
            default: pick = rq[0] ? 2'd0 : (rq[1] ? 2'd1 : 2'd2);
        endcase
        return pick;
    endfunction

    // ST, OP, PHYAD, REGAD, TA and data; reads leave TA/data released (all ones).
    function automatic logic [31:0] build_word(input logic [1:0] g, input logic wr_bit,
                                               input logic [14:0] ra, input logic [47:0] wd);
        logic [4:0]  phy;
        logic [4:0]  regad;
        logic [15:0] data;
        case (g)
            2'd1:    begin phy = PHY_ADDR_A; regad = ra[9:5];   data = wd[31:16]; end
            2'd2:    begin phy = PHY_ADDR_B; regad = ra[14:10]; data = wd[47:32]; end
            default: begin phy = PHY_ADDR_U; regad = ra[4:0];   data = wd[15:0];  end
        endcase
        if (wr_bit) begin
            return {2'b01, 2'b01, phy, regad, 2'b10, data};
        end else begin
            return {2'b01, 2'b10, phy, regad, 2'b11, 16'hFFFF};
        end
    endfunction

    // Next-state and output computation for the arbiter and frame serialiser.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        word_d    = word_q;
        div_d     = div_q;
        bit_d     = bit_q;
        rsh_d     = rsh_q;
        ta_d      = ta_q;
        done_d    = 3'b000;
        rdata_d   = rdata_q;
        rd_err_d  = rd_err_q;
        busy_d    = busy_q;
        mdc_d     = mdc_q;
        mdio_o_d  = mdio_o_q;
        mdio_oe_d = mdio_oe_q;
        pick_s    = rr_pick(ptr_q, bus.req);
        bit_nx_s  = bit_q + 6'd1;
        case (pick_s)
            2'd1:    pick_wr_s = bus.wr[1];
            2'd2:    pick_wr_s = bus.wr[2];
            default: pick_wr_s = bus.wr[0];
        endcase

        case (state_q)
            S_IDLE: begin
                if (bus.req != 3'b000) begin
                    idx_d   = pick_s;
                    ptr_d   = pick_s;
                    wr_d    = pick_wr_s;
                    word_d  = build_word(pick_s, pick_wr_s, bus.reg_addr, bus.wdata);
                    busy_d  = 1'b1;
                    state_d = S_GRANT;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            S_GRANT: begin
                div_d     = {DIV_W{1'b0}};
                bit_d     = 6'd0;
                rsh_d     = 16'h0000;
                ta_d      = 1'b0;
                mdc_d     = 1'b0;
                mdio_o_d  = 1'b1;
                mdio_oe_d = 1'b1;
                state_d   = S_FRAME;
            end
            S_FRAME: begin
                if (div_q == DIV_RISE) begin
                    // PHY data is taken on the same edge MDC rises.
                    div_d = div_q + DIV_ONE;
                    mdc_d = 1'b1;
                    if (bit_q == 6'd47) begin
                        ta_d = mdio_i;
                    end else begin
                        ta_d = ta_q;
                    end
                    if (bit_q >= 6'd48) begin
                        rsh_d = {rsh_q[14:0], mdio_i};
                    end else begin
                        rsh_d = rsh_q;
                    end
                end else if (div_q == DIV_LAST) begin
                    div_d = {DIV_W{1'b0}};
                    if (bit_q == 6'd63) begin
                        done_d = 3'b001 << idx_q;
                        if (wr_q) begin
                            rd_err_d = 1'b0;
                        end else begin
                            rdata_d  = rsh_q;
                            rd_err_d = ta_q;
                        end
                        mdio_oe_d = 1'b0;
                        mdio_o_d  = 1'b1;
                        state_d   = S_GAP;
                    end else begin
                        bit_d = bit_nx_s;
                        mdc_d = 1'b0;
                        if (bit_nx_s >= 6'd32) begin
                            mdio_o_d = word_q[31];
                            word_d   = {word_q[30:0], 1'b0};
                        end else begin
                            mdio_o_d = 1'b1;
                        end
                        // Reads hand the bus to the PHY for the turnaround.
                        if (!wr_q && (bit_nx_s == 6'd46)) begin
                            mdio_oe_d = 1'b0;
                        end else begin
                            mdio_oe_d = mdio_oe_q;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            S_GAP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = {DIV_W{1'b0}};
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    div_d   = div_q + DIV_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge gtx_clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= 2'd2;
            idx_q     <= 2'd0;
            wr_q      <= 1'b0;
            word_q    <= 32'h0000_0000;
            div_q     <= {DIV_W{1'b0}};
            bit_q     <= 6'd0;
            rsh_q     <= 16'h0000;
            ta_q      <= 1'b0;
            done_q    <= 3'b000;
            rdata_q   <= 16'h0000;
            rd_err_q  <= 1'b0;
            busy_q    <= 1'b0;
            mdc_q     <= 1'b1;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            wr_q      <= wr_d;
            word_q    <= word_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            rsh_q     <= rsh_d;
            ta_q      <= ta_d;
            done_q    <= done_d;
            rdata_q   <= rdata_d;
            rd_err_q  <= rd_err_d;
            busy_q    <= busy_d;
            mdc_q     <= mdc_d;
            mdio_o_q  <= mdio_o_d;
            mdio_oe_q <= mdio_oe_d;
        end
    end

    assign bus.done   = done_q;
    assign bus.rdata  = rdata_q;
    assign bus.rd_err = rd_err_q;
    assign bus.busy   = busy_q;
    assign mdc        = mdc_q;
    assign mdio_o     = mdio_o_q;
    assign mdio_oe    = mdio_oe_q;
endmodule

// File: tb/tb_mdio_phy_arbiter.sv
// Random requester traffic against a cycle-level reference model (HALF=5 instance),
// plus one directed write on a default-parameter instance.
module tb_mdio_phy_arbiter;
    localparam int H       = 5;
    localparam int BITC    = 2 * H;
    localparam int FRAME_C = 64 * BITC;
    localparam int NCYC    = 30000;

    logic gtx_clk = 1'b0;
    always #4 gtx_clk = ~gtx_clk;

    logic reset, mdc, mdio_o, mdio_oe, mdio_i;
    logic reset2, mdc2, mdio_o2, mdio_oe2, mdio_i2;

    mdio_phy_arbiter_if rq ();
    mdio_phy_arbiter_if rq2 ();

    mdio_phy_arbiter #(.CLK_FREQ(125_000_000), .MDC_FREQ(12_500_000)) dut (
        .gtx_clk(gtx_clk), .reset(reset), .bus(rq), .mdc(mdc),
        .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i));

    mdio_phy_arbiter dut_def (
        .gtx_clk(gtx_clk), .reset(reset2), .bus(rq2), .mdc(mdc2),
        .mdio_o(mdio_o2), .mdio_oe(mdio_oe2), .mdio_i(mdio_i2));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // reference model state
    int          ptr_m, free_m, g_start, g_idx, n_grants, n_obs, n_rderr, n_rd, k, b;
    bit          act, g_wr, g_te, rst_done, dir_done;
    logic [63:0] g_frame;
    logic [15:0] g_pd;
    logic [2:0]  pend, wrv, e_done;
    logic [4:0]  ra [3];
    logic [15:0] wd [3];
    logic [15:0] pd [3];
    logic        te [3];
    logic [15:0] exp_rdata;
    logic        exp_rderr, e_mdc, e_oe, e_o, e_busy;
    logic [2:0]  obs_order [4];
    logic [2:0]  want_order [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

    initial begin
        reset = 1'b1; mdio_i = 1'b1;
        pend = 3'b000; wrv = 3'b000;
        for (int i = 0; i < 3; i++) begin
            ra[i] = 5'd0; wd[i] = 16'd0; pd[i] = 16'd0; te[i] = 1'b0;
        end
        rq.req = 3'b000; rq.wr = 3'b000; rq.reg_addr = 15'd0; rq.wdata = 48'd0;
        ptr_m = 2; free_m = 4; act = 1'b0; n_grants = 0; n_obs = 0; n_rderr = 0; n_rd = 0;
        rst_done = 1'b0; exp_rdata = 16'h0000; exp_rderr = 1'b0;
        g_start = 0; g_idx = 0; g_wr = 1'b0; g_te = 1'b0; g_pd = 16'h0; g_frame = 64'h0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge gtx_clk);
            // expected outputs for this cycle
            e_mdc = 1'b1; e_oe = 1'b0; e_o = 1'b1; e_done = 3'b000;
            e_busy = act && (cyc >= g_start - 1) && (cyc < free_m);
            if (act && cyc >= g_start && cyc < g_start + FRAME_C) begin
                k = cyc - g_start;
                b = k / BITC;
                e_mdc = ((k % BITC) >= H);
                e_oe  = g_wr || (b < 46);
                e_o   = g_frame[63 - b];
            end
            if (act && cyc == g_start + FRAME_C) begin
                e_done = 3'b001 << g_idx;
                if (g_wr) begin
                    exp_rderr = 1'b0;
                end else begin
                    exp_rdata = g_pd;
                    exp_rderr = g_te;
                    n_rd++;
                end
                pend[g_idx] = 1'b0;
            end
            chk("done", rq.done, e_done);
            chk("busy", rq.busy, e_busy);
            chk("mdc", mdc, e_mdc);
            chk("mdio_oe", mdio_oe, e_oe);
            if (e_oe) chk("mdio_o", mdio_o, e_o);
            chk("rdata", rq.rdata, exp_rdata);
            chk("rd_err", rq.rd_err, exp_rderr);

            if (rq.done != 3'b000) begin
                if (n_obs < 4) obs_order[n_obs] = rq.done;
                n_obs++;
                if (rq.rd_err) n_rderr++;
            end
            if (act && cyc >= free_m - 1) act = 1'b0;

            // reset: power-on, and once at the start of bit 40 of a write
            reset = (cyc < 4);
            if (!reset && !rst_done && act && g_wr && n_grants >= 5 && cyc == g_start + 40 * BITC) begin
                reset = 1'b1; rst_done = 1'b1; act = 1'b0; ptr_m = 2; free_m = cyc + 1;
                pend = 3'b000; exp_rdata = 16'h0000; exp_rderr = 1'b0;
            end

            // requesters: all busy for the first four grants, random afterwards
            if (!reset) begin
                for (int i = 0; i < 3; i++) begin
                    if (!pend[i] && (n_grants < 4 || $urandom_range(0, 29) == 0)) begin
                        pend[i] = 1'b1;
                        wrv[i]  = (n_grants >= 4 && !rst_done) ? 1'b1 : 1'($urandom_range(0, 1));
                        ra[i]   = 5'($urandom);
                        wd[i]   = 16'($urandom);
                        pd[i]   = 16'($urandom);
                        te[i]   = ($urandom_range(0, 3) == 0);
                    end
                end
            end
            rq.req      = pend;
            rq.wr       = wrv;
            rq.reg_addr = {ra[2], ra[1], ra[0]};
            rq.wdata    = {wd[2], wd[1], wd[0]};

            // PHY model: turnaround bit then read data, MSB first
            mdio_i = 1'b1;
            if (act && !g_wr && cyc >= g_start && cyc < g_start + FRAME_C) begin
                b = (cyc - g_start) / BITC;
                if (b == 46) mdio_i = 1'($urandom_range(0, 1));
                else if (b == 47) mdio_i = g_te;
                else if (b >= 48) mdio_i = g_pd[63 - b];
            end

            // model arbitration
            if (!reset && !act && cyc >= free_m && pend != 3'b000) begin
                for (int s = 1; s <= 3; s++) begin
                    if (!act && pend[(ptr_m + s) % 3]) begin
                        g_idx = (ptr_m + s) % 3;
                        act = 1'b1;
                    end
                end
                ptr_m   = g_idx;
                g_start = cyc + 2;
                free_m  = g_start + FRAME_C + BITC;
                n_grants++;
                g_wr    = wrv[g_idx];
                g_te    = te[g_idx];
                g_pd    = pd[g_idx];
                g_frame = {32'hFFFF_FFFF, 2'b01, (g_wr ? 2'b01 : 2'b10), 5'(g_idx + 1),
                           ra[g_idx], 2'b10, wd[g_idx]};
            end
        end

        for (int w = 0; w < 5000 && !dir_done; w++) @(negedge gtx_clk);
        chk("directed_finished", dir_done, 1);
        chk("order_count", (n_obs >= 4), 1);
        for (int i = 0; i < 4; i++) chk("grant_order", obs_order[i], want_order[i]);
        chk("rd_err_seen", (n_rderr > 0), 1);
        chk("midframe_reset_hit", rst_done, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Default-parameter instance: single write from A, 3202-cycle latency
    logic [63:0] cap2;
    logic [63:0] want2;
    int          nb2;
    logic        prev_mdc2;
    bit          seen2;

    initial begin
        dir_done = 1'b0;
        reset2 = 1'b1; mdio_i2 = 1'b1;
        rq2.req = 3'b000; rq2.wr = 3'b000; rq2.reg_addr = 15'd0; rq2.wdata = 48'd0;
        want2 = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'b00010, 5'b00000, 2'b10, 16'h1140};
        cap2 = 64'h0; nb2 = 0; prev_mdc2 = 1'b1; seen2 = 1'b0;
        repeat (3) @(negedge gtx_clk);
        chk("def_reset_mdc", mdc2, 1);
        chk("def_reset_busy", rq2.busy, 0);
        reset2 = 1'b0;
        rq2.req = 3'b010; rq2.wr = 3'b010; rq2.reg_addr = 15'h0000;
        rq2.wdata = {16'h0000, 16'h1140, 16'h0000};
        for (int c = 0; c < 4000 && !seen2; c++) begin
            @(negedge gtx_clk);
            if (c == 0) chk("def_grant_busy", rq2.busy, 1);
            if (c == 1) begin
                chk("def_first_fall", mdc2, 0);
                chk("def_drive", mdio_oe2, 1);
            end
            if (!prev_mdc2 && mdc2) begin
                cap2 = {cap2[62:0], mdio_o2};
                nb2++;
            end
            prev_mdc2 = mdc2;
            if (rq2.done != 3'b000) begin
                seen2 = 1'b1;
                chk("def_done", rq2.done, 3'b010);
                chk("def_latency", c + 1, 3202);
                chk("def_bits", nb2, 64);
                chk("def_frame", cap2, want2);
                chk("def_rdata", rq2.rdata, 16'h0000);
                chk("def_rd_err", rq2.rd_err, 0);
                rq2.req = 3'b000;
            end
        end
        if (!seen2) chk("def_timeout", 0, 1);
        dir_done = 1'b1;
    end
endmodule
